// File: rtl/sa_sched_pkg.sv
// Shared state encoding and sizing helpers for the systolic-array tile scheduler.
package sa_sched_pkg;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StLoadWgt = 4'd1,
    StWaitWgt = 4'd2,
    StLoadIfm = 4'd3,
    StWaitIfm = 4'd4,
    StCompute = 4'd5,
    StWaitCmp = 4'd6,
    StAdvance = 4'd7,
    StDone    = 4'd8
  } sched_state_e;

  localparam int unsigned WatchdogWidth = 16;

  function automatic int unsigned ofm_rows(input int unsigned ifm_size,
                                           input int unsigned kernel_size);
    return ifm_size - kernel_size + 1;
  endfunction

  function automatic int unsigned tiles_per_row(input int unsigned ifm_size,
                                                input int unsigned tile_width);
    return (ifm_size + tile_width - 1) / tile_width;
  endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Tile row/column counters and the registered IFM base address of the current tile.
module tile_addr_gen
  import sa_sched_pkg::*;
#(
  parameter int unsigned IFM_SIZE    = 416,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned TILE_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 19,
  localparam int unsigned CntW       = $clog2(IFM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  advance,
  output logic [CntW-1:0]       tile_row,
  output logic [CntW-1:0]       tile_col,
  output logic [ADDR_WIDTH-1:0] tile_base,
  output logic                  last_tile
);

  localparam logic [CntW-1:0] LastRow = CntW'(ofm_rows(IFM_SIZE, KERNEL_SIZE) - 1);
  localparam logic [CntW-1:0] LastCol = CntW'(tiles_per_row(IFM_SIZE, TILE_WIDTH) - 1);
  localparam logic [ADDR_WIDTH-1:0] RowStep = ADDR_WIDTH'(IFM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] ColStep = ADDR_WIDTH'(TILE_WIDTH);

  logic [CntW-1:0]       row_q, row_d;
  logic [CntW-1:0]       col_q, col_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;

  assign last_tile = (row_q == LastRow) && (col_q == LastCol);

  // Base address is built incrementally so no multiplier is needed.
  always_comb begin
    row_d      = row_q;
    col_d      = col_q;
    base_d     = base_q;
    row_base_d = row_base_q;
    if (clear) begin
      row_d      = '0;
      col_d      = '0;
      base_d     = '0;
      row_base_d = '0;
    end else if (advance && !last_tile) begin
      if (col_q == LastCol) begin
        col_d      = '0;
        row_d      = row_q + 1'b1;
        row_base_d = row_base_q + RowStep;
        base_d     = row_base_q + RowStep;
      end else begin
        col_d  = col_q + 1'b1;
        base_d = base_q + ColStep;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q      <= '0;
      col_q      <= '0;
      base_q     <= '0;
      row_base_q <= '0;
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      base_q     <= base_d;
      row_base_q <= row_base_d;
    end
  end

  assign tile_row  = row_q;
  assign tile_col  = col_q;
  assign tile_base = base_q;

endmodule

// File: rtl/tile_scheduler.sv
// Layer-level sequencer: loads weights once, then fetches and computes every output tile.
// Optional watchdog on the WAIT states is enabled by defining SCHED_TIMEOUT_EN.
module tile_scheduler
  import sa_sched_pkg::*;
#(
  parameter int unsigned IFM_SIZE    = 416,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned TILE_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 19
`ifdef SCHED_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        wgt_done,
  input  logic                        ifm_done,
  input  logic                        cmp_done,
  output logic                        wgt_load,
  output logic                        ifm_load,
  output logic                        cmp_start,
  output logic [ADDR_WIDTH-1:0]       tile_base,
  output logic [$clog2(IFM_SIZE)-1:0] tile_row,
  output logic [$clog2(IFM_SIZE)-1:0] tile_col,
  output logic                        busy,
  output logic                        layer_done
`ifdef SCHED_TIMEOUT_EN
  , output logic                      err
`endif
);

  sched_state_e state_q, state_d;
  logic         last_tile;
  logic         wgt_load_q, ifm_load_q, cmp_start_q, busy_q, layer_done_q;

`ifdef SCHED_TIMEOUT_EN
  logic [WatchdogWidth-1:0] wd_q, wd_d;
  logic                     err_q, err_d;
  logic                     in_wait, timeout_hit, timeout;

  assign in_wait     = (state_q == StWaitWgt) || (state_q == StWaitIfm) ||
                       (state_q == StWaitCmp);
  assign timeout_hit = in_wait && (wd_q == WatchdogWidth'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d = state_q;
`ifdef SCHED_TIMEOUT_EN
    timeout = 1'b0;
`endif
    unique case (state_q)
      StIdle:    if (start) state_d = StLoadWgt;
      StLoadWgt: state_d = StWaitWgt;
      StWaitWgt: if (wgt_done) state_d = StLoadIfm;
      StLoadIfm: state_d = StWaitIfm;
      StWaitIfm: if (ifm_done) state_d = StCompute;
      StCompute: state_d = StWaitCmp;
      StWaitCmp: if (cmp_done) state_d = StAdvance;
      StAdvance: state_d = last_tile ? StDone : StLoadIfm;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
`ifdef SCHED_TIMEOUT_EN
    // A done pulse landing on the expiry cycle still wins over the watchdog.
    if (timeout_hit && (state_d == state_q)) begin
      state_d = StIdle;
      timeout = 1'b1;
    end
`endif
    if (abort) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wgt_load_q   <= 1'b0;
      ifm_load_q   <= 1'b0;
      cmp_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wgt_load_q   <= (state_d == StLoadWgt);
      ifm_load_q   <= (state_d == StLoadIfm);
      cmp_start_q  <= (state_d == StCompute);
      busy_q       <= (state_d != StIdle);
      layer_done_q <= (state_d == StDone);
    end
  end

`ifdef SCHED_TIMEOUT_EN
  // Any state change restarts the count, so each WAIT entry starts from zero.
  always_comb begin
    wd_d  = wd_q;
    err_d = err_q;
    if (state_d != state_q) begin
      wd_d = '0;
    end else if (in_wait) begin
      wd_d = wd_q + 1'b1;
    end
    if (start && (state_q == StIdle)) err_d = 1'b0;
    if (timeout) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

  // Counters are held at zero whenever the block is idle or about to be.
  tile_addr_gen #(
    .IFM_SIZE   (IFM_SIZE),
    .KERNEL_SIZE(KERNEL_SIZE),
    .TILE_WIDTH (TILE_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_tile_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_d == StIdle),
    .advance  (state_q == StAdvance),
    .tile_row (tile_row),
    .tile_col (tile_col),
    .tile_base(tile_base),
    .last_tile(last_tile)
  );

  assign wgt_load   = wgt_load_q;
  assign ifm_load   = ifm_load_q;
  assign cmp_start  = cmp_start_q;
  assign busy       = busy_q;
  assign layer_done = layer_done_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler on an 8x8 IFM with 3x3 kernel and 4-wide tiles.
// Define SCHED_TIMEOUT_EN to also exercise the watchdog.
module tb_tile_scheduler;
  import sa_sched_pkg::*;

  localparam int unsigned IfmSize    = 8;
  localparam int unsigned KernelSize = 3;
  localparam int unsigned TileWidth  = 4;
  localparam int unsigned AddrWidth  = 19;
  localparam int unsigned CntW       = $clog2(IfmSize);
  localparam int          NumTiles   = 12;

  logic                 clk = 1'b0;
  logic                 rst, start, abort, wgt_done, ifm_done, cmp_done;
  logic                 wgt_load, ifm_load, cmp_start, busy, layer_done;
  logic [AddrWidth-1:0] tile_base;
  logic [CntW-1:0]      tile_row, tile_col;
`ifdef SCHED_TIMEOUT_EN
  logic                 err;
`endif

  always #5 clk = ~clk;

  tile_scheduler #(
    .IFM_SIZE   (IfmSize),
    .KERNEL_SIZE(KernelSize),
    .TILE_WIDTH (TileWidth),
    .ADDR_WIDTH (AddrWidth)
`ifdef SCHED_TIMEOUT_EN
    , .TIMEOUT_CYCLES(20)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .wgt_done  (wgt_done),
    .ifm_done  (ifm_done),
    .cmp_done  (cmp_done),
    .wgt_load  (wgt_load),
    .ifm_load  (ifm_load),
    .cmp_start (cmp_start),
    .tile_base (tile_base),
    .tile_row  (tile_row),
    .tile_col  (tile_col),
    .busy      (busy),
    .layer_done(layer_done)
`ifdef SCHED_TIMEOUT_EN
    , .err     (err)
`endif
  );

  // Hand-computed tile sequence: base = row*8 + col*4, two tiles per row, six rows.
  int exp_base[NumTiles] = '{0, 4, 8, 12, 16, 20, 24, 28, 32, 36, 40, 44};
  int exp_row[NumTiles]  = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};
  int exp_col[NumTiles]  = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

  int n_cmp, n_fail;
  int wgt_cnt, ifm_cnt, cmp_cnt, done_cnt;
  int wgt_cd, ifm_cd, cmp_cd;
  bit hold_ifm, inject_cmp;
  int base_log[NumTiles];
  int row_log[NumTiles];
  int col_log[NumTiles];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    wgt_cnt  = 0;
    ifm_cnt  = 0;
    cmp_cnt  = 0;
    done_cnt = 0;
    wgt_cd   = 0;
    ifm_cd   = 0;
    cmp_cd   = 0;
    for (int i = 0; i < NumTiles; i++) begin
      base_log[i] = -1;
      row_log[i]  = -1;
      col_log[i]  = -1;
    end
  endtask

  // One cycle: observe outputs at the falling edge, then drive the 3-cycle responders.
  task automatic tick();
    @(negedge clk);
    if (wgt_load) wgt_cnt++;
    if (ifm_load) begin
      if (ifm_cnt < NumTiles) begin
        base_log[ifm_cnt] = int'(tile_base);
        row_log[ifm_cnt]  = int'(tile_row);
        col_log[ifm_cnt]  = int'(tile_col);
      end
      ifm_cnt++;
    end
    if (cmp_start) cmp_cnt++;
    if (layer_done) done_cnt++;
    wgt_done = 1'b0;
    ifm_done = 1'b0;
    cmp_done = 1'b0;
    if (wgt_load) wgt_cd = 3;
    else if (wgt_cd > 0) begin
      wgt_cd--;
      wgt_done = (wgt_cd == 0);
    end
    if (ifm_load) ifm_cd = 3;
    else if (ifm_cd > 0) begin
      ifm_cd--;
      ifm_done = (ifm_cd == 0) && !hold_ifm;
    end
    if (cmp_start) cmp_cd = 3;
    else if (cmp_cd > 0) begin
      cmp_cd--;
      cmp_done = (cmp_cd == 0);
    end
    if (inject_cmp) cmp_done = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ifm(input int target, input int budget);
    int n = 0;
    while (ifm_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check_val("ifm_load_reached", 32'(ifm_cnt >= target), 1);
  endtask

  task automatic wait_layer_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check_val("layer_done_seen", 32'(done_cnt), 1);
    check_val("busy_in_done", 32'(busy), 1);
    tick();
    check_val("busy_after_done", 32'(busy), 0);
    check_val("layer_done_one_cycle", 32'(layer_done), 0);
  endtask

  task automatic check_layer(input string tag);
    check_val({tag, "_wgt_load_cnt"}, 32'(wgt_cnt), 1);
    check_val({tag, "_ifm_load_cnt"}, 32'(ifm_cnt), NumTiles);
    check_val({tag, "_cmp_start_cnt"}, 32'(cmp_cnt), NumTiles);
    check_val({tag, "_layer_done_cnt"}, 32'(done_cnt), 1);
    for (int i = 0; i < NumTiles; i++) begin
      check_val($sformatf("%s_base%0d", tag, i), 32'(base_log[i]), 32'(exp_base[i]));
      check_val($sformatf("%s_row%0d", tag, i), 32'(row_log[i]), 32'(exp_row[i]));
      check_val($sformatf("%s_col%0d", tag, i), 32'(col_log[i]), 32'(exp_col[i]));
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    wgt_done   = 1'b0;
    ifm_done   = 1'b0;
    cmp_done   = 1'b0;
    hold_ifm   = 1'b0;
    inject_cmp = 1'b0;
    clear_counts();
    repeat (3) tick();
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_wgt_load", 32'(wgt_load), 0);
    check_val("rst_ifm_load", 32'(ifm_load), 0);
    check_val("rst_cmp_start", 32'(cmp_start), 0);
    check_val("rst_layer_done", 32'(layer_done), 0);
    check_val("rst_tile_base", 32'(tile_base), 0);
    check_val("rst_tile_row", 32'(tile_row), 0);
    check_val("rst_tile_col", 32'(tile_col), 0);
`ifdef SCHED_TIMEOUT_EN
    check_val("rst_err", 32'(err), 0);
`endif
    rst = 1'b0;
    tick();

    // Plain layer.
    clear_counts();
    pulse_start();
    check_val("s1_busy_after_start", 32'(busy), 1);
    check_val("s1_wgt_load_pulse", 32'(wgt_load), 1);
    wait_layer_done(500);
    check_layer("s1");

    // Stray cmp_done while waiting on the IFM fetch.
    clear_counts();
    pulse_start();
    wait_ifm(1, 50);
    inject_cmp = 1'b1;
    tick();
    inject_cmp = 1'b0;
    tick();
    check_val("s2_state_wait_ifm", 32'(dut.state_q), 32'(StWaitIfm));
    check_val("s2_no_early_cmp", 32'(cmp_cnt), 0);
    wait_layer_done(500);
    check_layer("s2");

    // Abort during the 5th tile, then a simultaneous start+abort, then a clean restart.
    clear_counts();
    pulse_start();
    wait_ifm(5, 200);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("s3_abort_busy", 32'(busy), 0);
    check_val("s3_abort_state", 32'(dut.state_q), 32'(StIdle));
    check_val("s3_abort_base", 32'(tile_base), 0);
    check_val("s3_abort_row", 32'(tile_row), 0);
    check_val("s3_abort_col", 32'(tile_col), 0);
    repeat (8) tick();
    check_val("s3_no_ifm_after_abort", 32'(ifm_cnt), 5);
    check_val("s3_no_cmp_after_abort", 32'(cmp_cnt), 4);
    check_val("s3_no_done_after_abort", 32'(done_cnt), 0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_val("s3_abort_beats_start", 32'(busy), 0);
    clear_counts();
    pulse_start();
    wait_layer_done(500);
    check_layer("s3");

    // Extra start pulses while busy are ignored.
    clear_counts();
    pulse_start();
    repeat (3) tick();
    pulse_start();
    wait_ifm(3, 100);
    pulse_start();
    wait_layer_done(500);
    check_layer("s4");

`ifdef SCHED_TIMEOUT_EN
    // Withhold ifm_done; watchdog fires 20 cycles after entering WAIT_IFM.
    clear_counts();
    hold_ifm = 1'b1;
    pulse_start();
    wait_ifm(1, 50);
    repeat (20) tick();
    check_val("s5_still_waiting", 32'(busy), 1);
    check_val("s5_err_not_yet", 32'(err), 0);
    tick();
    check_val("s5_timeout_idle", 32'(busy), 0);
    check_val("s5_timeout_state", 32'(dut.state_q), 32'(StIdle));
    check_val("s5_err_set", 32'(err), 1);
    hold_ifm = 1'b0;
    repeat (4) tick();
    check_val("s5_err_sticky", 32'(err), 1);
    clear_counts();
    pulse_start();
    check_val("s5_err_cleared", 32'(err), 0);
    wait_layer_done(500);
    check_layer("s5");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
